fetch_stage: RTL

- Instruction-fetch stage directly upstream of the decode stage.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned instructions, tagged with their PCs, in a small queue.
- Presents them to decode over a valid/ready handshake. A redirect (jump/call/ret resolved downstream) flushes the queue and silently discards in-flight stale responses.

---
 rtl/fetch_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, in-order imem requests,
// tagged instruction queue toward decode, redirect flush.
module fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_INC     = 4,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_resp_valid,
  input  logic [31:0]           imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  output logic [31:0]           if_instruction,
  output logic [ADDR_WIDTH-1:0] if_pc,
  input  logic                  id_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] INC =
    ADDR_WIDTH'(PC_INC);
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_resp_pc;
  logic [CW-1:0]         r_wptr;
  logic [CW-1:0]         r_rptr;
  logic [CW-1:0]         r_out;
  logic [CW-1:0]         r_drop;
  logic [31:0]           r_ins [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_tag [FIFO_DEPTH];

  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_credit;
  logic          w_fire;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic [PW-1:0] w_widx;
  logic [PW-1:0] w_ridx;

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) &&
                   (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_widx  = r_wptr[PW-1:0];
  assign w_ridx  = r_rptr[PW-1:0];

  // Credit uses registered occupancy only; a
  // same-cycle pop frees nothing until next cycle.
  assign w_credit = ({1'b0, w_count} + {1'b0, r_out})
                    < DEPTH;

  assign imem_req_valid = !reset && !redirect_valid &&
                          w_credit;
  assign w_fire  = imem_req_valid && imem_req_ready;
  assign imem_addr = reset ? RESET_PC : r_pc;

  assign w_valid = !reset && !w_empty;
  assign w_pop   = w_valid && id_ready &&
                   !redirect_valid;
  assign w_push  = imem_resp_valid && (r_drop == '0) &&
                   !redirect_valid;

  assign if_valid       = w_valid;
  assign if_instruction = w_valid ? r_ins[w_ridx] : '0;
  assign if_pc          = w_valid ? r_tag[w_ridx] : '0;

  // PC, pointers, in-flight and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_out     <= '0;
      r_drop    <= '0;
    end else if (redirect_valid) begin
      r_pc      <= redirect_pc;
      r_resp_pc <= redirect_pc;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_out     <= r_out - CW'(imem_resp_valid);
      r_drop    <= r_out - CW'(imem_resp_valid);
    end else begin
      if (w_fire)
        r_pc <= r_pc + INC;
      if (w_push) begin
        r_wptr    <= r_wptr + ONE;
        r_resp_pc <= r_resp_pc + INC;
      end
      if (w_pop)
        r_rptr <= r_rptr + ONE;
      r_out <= r_out + CW'(w_fire) -
               CW'(imem_resp_valid);
      if (imem_resp_valid && (r_drop != '0))
        r_drop <= r_drop - ONE;
    end
  end

  // Queue storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ins[w_widx] <= imem_resp_data;
      r_tag[w_widx] <= r_resp_pc;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(w_push && w_full && !w_pop));

  a_out_bound: assert property (
    @(posedge clk) disable iff (reset)
    ({1'b0, r_out} <= DEPTH));

endmodule
